// File: rtl/block_seq_ctrl.sv
// Symbol sequencer between the Huffman/VLI decoder and block_buffer: tracks the zig-zag index,
// issues buffer writes, applies DC prediction when BLOCK_SEQ_DC_PRED_EN is defined.
module block_seq_ctrl #(
  parameter int unsigned NUM_COMP  = 3,
  parameter int unsigned BLK_COEFS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic        sym_is_dc,
  input  logic        sym_eob,
  input  logic        sym_zrl,
  input  logic [3:0]  sym_run,
  input  logic [11:0] sym_value,
  input  logic [1:0]  sym_comp,
  input  logic        restart,
  output logic [3:0]  buf_run,
  output logic [11:0] buf_value,
  output logic        buf_wr_en,
  input  logic        buf_valid,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [1:0]  blk_comp,
  output logic [6:0]  coef_idx,
  output logic        err
);

  localparam logic [2:0] NumCompW  = 3'(NUM_COMP);
  localparam logic [7:0] BlkCoefsW = 8'(BLK_COEFS);

  typedef enum logic [2:0] {StIdle, StAc, StFlush, StWaitBuf, StHold} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  run_q, run_d;
  logic [11:0] value_q, value_d;
  logic        blk_valid_q, blk_valid_d;
  logic [1:0]  blk_comp_q, blk_comp_d;
  logic [6:0]  coef_idx_q, coef_idx_d;
  logic        err_q, err_d;

  logic        sym_fire;
  logic        comp_bad;
  logic        dc_wr;
  logic [7:0]  adv;
  logic [7:0]  sum;
  logic [11:0] dc_value;

  assign sym_fire = sym_valid & ready_q;
  assign comp_bad = ({1'b0, sym_comp} >= NumCompW);
  assign adv      = sym_zrl ? 8'd16 : ({4'b0000, sym_run} + 8'd1);
  assign sum      = {1'b0, coef_idx_q} + adv;

`ifdef BLOCK_SEQ_DC_PRED_EN
  logic [3:0][11:0] pred_q, pred_d;
  logic [1:0]       comp_sel;
  logic [11:0]      pred_base;

  // Out-of-range components fall back to predictor 0.
  assign comp_sel  = comp_bad ? 2'd0 : sym_comp;
  assign pred_base = restart ? 12'd0 : pred_q[comp_sel];
  assign dc_value  = pred_base + sym_value;

  always_comb begin
    pred_d = pred_q;
    if (restart) pred_d = '0;
    if (dc_wr) pred_d[comp_sel] = dc_value;
  end

  always_ff @(posedge clk) begin
    if (!rst) pred_q <= '0;
    else      pred_q <= pred_d;
  end
`else
  logic unused_restart;
  assign unused_restart = restart;
  assign dc_value       = sym_value;
`endif

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    run_d       = run_q;
    value_d     = value_q;
    blk_valid_d = blk_valid_q;
    blk_comp_d  = blk_comp_q;
    coef_idx_d  = coef_idx_q;
    err_d       = err_q;
    dc_wr       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sym_fire) begin
          if (sym_is_dc) begin
            dc_wr      = 1'b1;
            err_d      = err_q | comp_bad;
            blk_comp_d = sym_comp;
            wr_en_d    = 1'b1;
            run_d      = 4'd0;
            value_d    = dc_value;
            coef_idx_d = 7'd1;
            state_d    = StAc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAc: begin
        if (sym_fire) begin
          // EOB, stray DC and overflow all end in the same flush write, loaded here
          // so it appears while the FSM sits in StFlush.
          if (sym_is_dc || sym_eob || (sum > BlkCoefsW)) begin
            err_d   = err_q | ~sym_eob | sym_is_dc;
            wr_en_d = 1'b1;
            run_d   = 4'd0;
            value_d = 12'd0;
            state_d = StFlush;
          end else begin
            wr_en_d    = 1'b1;
            run_d      = sym_zrl ? 4'd15 : sym_run;
            value_d    = sym_zrl ? 12'd0 : sym_value;
            coef_idx_d = sum[6:0];
            if (sum == BlkCoefsW) state_d = StWaitBuf;
          end
        end
      end
      StFlush: begin
        state_d = StWaitBuf;
      end
      StWaitBuf: begin
        if (buf_valid) begin
          blk_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (blk_valid_q && blk_ready) begin
          blk_valid_d = 1'b0;
          coef_idx_d  = 7'd0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle) || (state_d == StAc);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      run_q       <= 4'd0;
      value_q     <= 12'd0;
      blk_valid_q <= 1'b0;
      blk_comp_q  <= 2'd0;
      coef_idx_q  <= 7'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      run_q       <= run_d;
      value_q     <= value_d;
      blk_valid_q <= blk_valid_d;
      blk_comp_q  <= blk_comp_d;
      coef_idx_q  <= coef_idx_d;
      err_q       <= err_d;
    end
  end

  assign sym_ready = ready_q;
  assign buf_wr_en = wr_en_q;
  assign buf_run   = run_q;
  assign buf_value = value_q;
  assign blk_valid = blk_valid_q;
  assign blk_comp  = blk_comp_q;
  assign coef_idx  = coef_idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_block_seq_ctrl.sv
// Directed bench for block_seq_ctrl; expected DC values follow BLOCK_SEQ_DC_PRED_EN.
module tb_block_seq_ctrl;

`ifdef BLOCK_SEQ_DC_PRED_EN
  localparam bit PredEn = 1'b1;
`else
  localparam bit PredEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sym_valid = 1'b0, sym_ready;
  logic        sym_is_dc = 1'b0, sym_eob = 1'b0, sym_zrl = 1'b0;
  logic [3:0]  sym_run = 4'd0;
  logic [11:0] sym_value = 12'd0;
  logic [1:0]  sym_comp = 2'd0;
  logic        restart = 1'b0;
  logic [3:0]  buf_run;
  logic [11:0] buf_value;
  logic        buf_wr_en;
  logic        buf_valid = 1'b0;
  logic        blk_valid;
  logic        blk_ready = 1'b0;
  logic [1:0]  blk_comp;
  logic [6:0]  coef_idx;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  block_seq_ctrl #(.NUM_COMP(3), .BLK_COEFS(64)) dut (
    .clk(clk), .rst(rst),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
    .sym_eob(sym_eob), .sym_zrl(sym_zrl), .sym_run(sym_run), .sym_value(sym_value),
    .sym_comp(sym_comp), .restart(restart),
    .buf_run(buf_run), .buf_value(buf_value), .buf_wr_en(buf_wr_en), .buf_valid(buf_valid),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_comp(blk_comp),
    .coef_idx(coef_idx), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic dc, input logic eob, input logic zrl, input logic [3:0] run,
                     input logic [11:0] val, input logic [1:0] comp);
    sym_valid = 1'b1; sym_is_dc = dc; sym_eob = eob; sym_zrl = zrl;
    sym_run = run; sym_value = val; sym_comp = comp;
  endtask

  task automatic drop();
    sym_valid = 1'b0; sym_is_dc = 1'b0; sym_eob = 1'b0; sym_zrl = 1'b0;
  endtask

  task automatic do_reset();
    drop(); restart = 1'b0; buf_valid = 1'b0; blk_ready = 1'b0;
    rst = 1'b0; step(); step();
    rst = 1'b1; step();
  endtask

  // Called right after the flush-triggering symbol edge: FLUSH -> WAIT_BUF -> HOLD -> IDLE.
  task automatic finish_block();
    drop(); step();
    buf_valid = 1'b1; step();
    buf_valid = 1'b0; blk_ready = 1'b1; step();
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd5, 2'd0);
    step(); step();
    if (sym_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", sym_ready); end
    n_cmp++;
    if (buf_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr got %b want 0", buf_wr_en); end
    n_cmp++;
    if ({buf_run, buf_value} !== 16'd0) begin
      n_fail++; $display("FAIL rst_buf got %h want 0000", {buf_run, buf_value});
    end
    n_cmp++;
    if ({blk_valid, blk_comp, coef_idx, err} !== 11'd0) begin
      n_fail++; $display("FAIL rst_misc got %h want 000", {blk_valid, blk_comp, coef_idx, err});
    end
    n_cmp++;
    drop(); rst = 1'b1; step();
    if (sym_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b want 1", sym_ready); end
    n_cmp++;
  endtask

  task automatic test_basic();
    logic [3:0]  runs[4]  = '{4'd0, 4'd6, 4'd0, 4'd6};
    logic [11:0] vals[4]  = '{12'd10, 12'd511, 12'hFFF, 12'hE01};
    logic [6:0]  idxs[4]  = '{7'd1, 7'd8, 7'd9, 7'd16};
    for (int i = 0; i < 4; i++) begin
      put(i == 0, 1'b0, 1'b0, runs[i], vals[i], 2'd0);
      step();
      if ({buf_wr_en, buf_run, buf_value} !== {1'b1, runs[i], vals[i]}) begin
        n_fail++; $display("FAIL basic_wr%0d got %h want %h", i,
                           {buf_wr_en, buf_run, buf_value}, {1'b1, runs[i], vals[i]});
      end
      n_cmp++;
      if (coef_idx !== idxs[i]) begin
        n_fail++; $display("FAIL basic_idx%0d got %0d want %0d", i, coef_idx, idxs[i]);
      end
      n_cmp++;
    end
    put(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 2'd0);
    step();
    if ({buf_wr_en, buf_run, buf_value, sym_ready} !== {1'b1, 16'd0, 1'b0}) begin
      n_fail++; $display("FAIL basic_eob got %h want 10000/0", {buf_wr_en, buf_run, buf_value, sym_ready});
    end
    n_cmp++;
    drop(); step();
    if ({buf_wr_en, blk_valid} !== 2'b00) begin
      n_fail++; $display("FAIL basic_waitbuf got %b want 00", {buf_wr_en, blk_valid});
    end
    n_cmp++;
    buf_valid = 1'b1; step(); buf_valid = 1'b0;
    if ({blk_valid, blk_comp} !== 3'b100) begin
      n_fail++; $display("FAIL basic_blk got %b want 100", {blk_valid, blk_comp});
    end
    n_cmp++;
    blk_ready = 1'b1; step(); blk_ready = 1'b0;
    if ({blk_valid, coef_idx, sym_ready, err} !== {1'b0, 7'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_done got %h want 002", {blk_valid, coef_idx, sym_ready, err});
    end
    n_cmp++;
  endtask

  task automatic test_dc_pred();
    logic [11:0] diffs[5] = '{12'd100, -12'sd30, -12'sd30, 12'd5, 12'd1};
    logic [11:0] expv[5];
    logic        rs_pre[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        rs_with[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    expv = '{12'd100, PredEn ? 12'd70 : -12'sd30, -12'sd30, 12'd5, PredEn ? 12'd6 : 12'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (rs_pre[i]) begin restart = 1'b1; step(); restart = 1'b0; end
      restart = rs_with[i];
      put(1'b1, 1'b0, 1'b0, 4'd0, diffs[i], 2'd0);
      step();
      restart = 1'b0;
      if ({buf_wr_en, buf_value} !== {1'b1, expv[i]}) begin
        n_fail++; $display("FAIL pred_dc%0d got %h want %h", i, {buf_wr_en, buf_value},
                           {1'b1, expv[i]});
      end
      n_cmp++;
      put(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 2'd0);
      step();
      finish_block();
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp2;
    exp2 = PredEn ? 12'h80C : 12'd20;
    do_reset();
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd2040, 2'd1);
    step();
    if (buf_value !== 12'd2040) begin
      n_fail++; $display("FAIL wrap_first got %h want %h", buf_value, 12'd2040);
    end
    n_cmp++;
    put(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 2'd1); step(); finish_block();
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd20, 2'd1);
    step();
    if (buf_value !== exp2) begin
      n_fail++; $display("FAIL wrap_dc got %h want %h", buf_value, exp2);
    end
    n_cmp++;
    put(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 2'd1); step(); finish_block();
  endtask

  task automatic test_full_and_hold();
    do_reset();
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 2'd2); step();
    for (int i = 0; i < 3; i++) begin
      put(1'b0, 1'b0, 1'b1, 4'd0, 12'd0, 2'd2); step();
      if ({buf_wr_en, buf_run, buf_value, coef_idx} !== {1'b1, 4'd15, 12'd0, 7'(17 + 16 * i)}) begin
        n_fail++; $display("FAIL zrl%0d got %h want %h", i, {buf_wr_en, buf_run, buf_value, coef_idx},
                           {1'b1, 4'd15, 12'd0, 7'(17 + 16 * i)});
      end
      n_cmp++;
    end
    put(1'b0, 1'b0, 1'b0, 4'd14, 12'd5, 2'd2); step();
    if ({buf_wr_en, buf_run, buf_value, coef_idx, sym_ready, err} !==
        {1'b1, 4'd14, 12'd5, 7'd64, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL full_last got %h want %h", {buf_wr_en, buf_run, buf_value, coef_idx,
                         sym_ready, err}, {1'b1, 4'd14, 12'd5, 7'd64, 1'b0, 1'b0});
    end
    n_cmp++;
    drop(); step();
    if ({buf_wr_en, sym_ready} !== 2'b00) begin
      n_fail++; $display("FAIL full_noeob got %b want 00", {buf_wr_en, sym_ready});
    end
    n_cmp++;
    buf_valid = 1'b1; step(); buf_valid = 1'b0;
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd7, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      if ({sym_ready, blk_valid, blk_comp, buf_wr_en} !== 5'b01100) begin
        n_fail++; $display("FAIL hold%0d got %b want 01100", i, {sym_ready, blk_valid, blk_comp, buf_wr_en});
      end
      n_cmp++;
    end
    blk_ready = 1'b1; step(); blk_ready = 1'b0;
    if ({blk_valid, sym_ready, coef_idx, buf_wr_en} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
      n_fail++; $display("FAIL hold_rel got %h want %h", {blk_valid, sym_ready, coef_idx, buf_wr_en},
                         {1'b0, 1'b1, 7'd0, 1'b0});
    end
    n_cmp++;
    step();
    if ({buf_wr_en, buf_value, coef_idx} !== {1'b1, 12'd7, 7'd1}) begin
      n_fail++; $display("FAIL next_dc got %h want %h", {buf_wr_en, buf_value, coef_idx},
                         {1'b1, 12'd7, 7'd1});
    end
    n_cmp++;
    put(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 2'd0); step(); finish_block();
  endtask

  task automatic test_overflow();
    do_reset();
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd3, 2'd1); step();
    for (int i = 0; i < 3; i++) begin
      put(1'b0, 1'b0, 1'b1, 4'd0, 12'd0, 2'd1); step();
    end
    put(1'b0, 1'b0, 1'b0, 4'd10, 12'd1, 2'd1); step();
    if (coef_idx !== 7'd60) begin n_fail++; $display("FAIL ovf_pre got %0d want 60", coef_idx); end
    n_cmp++;
    put(1'b0, 1'b0, 1'b0, 4'd5, 12'd9, 2'd1); step();
    if ({buf_wr_en, buf_run, buf_value, coef_idx, err, sym_ready} !==
        {1'b1, 4'd0, 12'd0, 7'd60, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ovf_flush got %h want %h", {buf_wr_en, buf_run, buf_value, coef_idx,
                         err, sym_ready}, {1'b1, 4'd0, 12'd0, 7'd60, 1'b1, 1'b0});
    end
    n_cmp++;
    drop(); step(); buf_valid = 1'b1; step(); buf_valid = 1'b0;
    if ({blk_valid, blk_comp} !== 3'b101) begin
      n_fail++; $display("FAIL ovf_blk got %b want 101", {blk_valid, blk_comp});
    end
    n_cmp++;
    blk_ready = 1'b1; step(); blk_ready = 1'b0;
    if ({sym_ready, err} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_sticky got %b want 11", {sym_ready, err});
    end
    n_cmp++;
  endtask

  task automatic test_errors();
    do_reset();
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b want 0", err); end
    n_cmp++;
    put(1'b0, 1'b0, 1'b0, 4'd3, 12'd4, 2'd0); step();
    if ({err, buf_wr_en, sym_ready, coef_idx} !== {1'b1, 1'b0, 1'b1, 7'd0}) begin
      n_fail++; $display("FAIL idle_ac got %h want %h", {err, buf_wr_en, sym_ready, coef_idx},
                         {1'b1, 1'b0, 1'b1, 7'd0});
    end
    n_cmp++;
    do_reset();
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd1, 2'd0); step();
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd2, 2'd0); step();
    if ({err, buf_wr_en, buf_value, sym_ready} !== {1'b1, 1'b1, 12'd0, 1'b0}) begin
      n_fail++; $display("FAIL dc_in_ac got %h want %h", {err, buf_wr_en, buf_value, sym_ready},
                         {1'b1, 1'b1, 12'd0, 1'b0});
    end
    n_cmp++;
    finish_block();
    do_reset();
    put(1'b1, 1'b0, 1'b0, 4'd0, 12'd9, 2'd3); step();
    if ({err, buf_wr_en, buf_value, coef_idx} !== {1'b1, 1'b1, 12'd9, 7'd1}) begin
      n_fail++; $display("FAIL comp_range got %h want %h", {err, buf_wr_en, buf_value, coef_idx},
                         {1'b1, 1'b1, 12'd9, 7'd1});
    end
    n_cmp++;
    put(1'b0, 1'b1, 1'b0, 4'd0, 12'd0, 2'd3); step(); finish_block();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dc_pred();
    test_wrap();
    test_full_and_hold();
    test_overflow();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
